mult4x4_arbiter: RTL
====================

MULT4X4_ARBITER -- requirements
Module: mult4x4_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: maximum number of WAIT cycles before a job aborts with an error.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports req0/req1, input, 1 each: requester i holds a job pending (level).
REQ-005 SHALL have ports mplier0/mplier1 and mcand0/mcand1, input, 4 each, signed: operands, stable while req_i is high.
REQ-006 SHALL have ports gnt0/gnt1, output, 1 each: one-cycle pulse when requester i's operands are captured.
REQ-007 SHALL have ports rsp_valid0/rsp_valid1, output, 1 each: one-cycle result pulse to requester i.
REQ-008 SHALL have ports rsp_prod, output, 9, signed, and rsp_err, output, 1: shared result bus, meaningful only while a rsp_valid_i is high.
REQ-009 SHALL have ports mul_st (output, 1), mul_mplier (output, 4, signed), mul_mcand (output, 4, signed), mul_prod (input, 9, signed) and mul_done (input, 1): connection to one sequential_signed_mult4x4 instance.

Function
REQ-010 SHALL implement FSM states IDLE, START, WAIT, RESP.
REQ-011 IDLE: if any req_i is high, SHALL pulse gnt for the winner, capture its operands into registers and the winner index, then go to START.
REQ-012 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; after reset requester 0 has priority.
REQ-013 With a single request, SHALL grant it regardless of the pointer; the pointer updates only on a grant.
REQ-014 START: SHALL drive mul_st high for exactly one cycle, then go to WAIT; mul_mplier/mul_mcand SHALL come from the captured registers and stay stable from START through WAIT.
REQ-015 WAIT: SHALL sample mul_done only in this state; mul_done high in any other state SHALL be ignored.
REQ-016 WAIT, mul_done high: SHALL register mul_prod into rsp_prod, clear rsp_err and go to RESP.
REQ-017 WAIT: SHALL count cycles; if TIMEOUT_CYC cycles pass without mul_done, SHALL set rsp_err=1, set rsp_prod=0 and go to RESP.
REQ-018 RESP: SHALL pulse rsp_valid for the captured winner index only, for one cycle, then return to IDLE.
REQ-019 Request-to-grant latency from IDLE SHALL be 1 cycle. The earliest rsp_valid SHALL be 2 cycles after mul_done is sampled.
REQ-020 SHALL process one job at a time; requests arriving while busy wait, with no queueing beyond the req level.
REQ-021 A requester SHALL NOT be granted twice in a row while the other requester is requesting.
REQ-022 rsp_prod SHALL hold the full 9-bit signed product unchanged, with no truncation or re-extension.

Reset
REQ-023 When rst_n is low, SHALL asynchronously force: state IDLE, all gnt/rsp_valid/mul_st/rsp_err outputs 0, rsp_prod 0, mul_mplier/mul_mcand 0, timeout counter 0, pointer to requester-0 priority.
REQ-024 Reset during START or WAIT SHALL abandon the job with no rsp_valid issued; after release, SHALL resume arbitration from IDLE.

Structure
REQ-025 The shared package SHALL hold the FSM state encoding, the operand width (4), the product width (9) and the TIMEOUT_CYC default.
REQ-026 SHALL contain one natural sub-module, rr_arb2: a 2-way round-robin grant with pointer; the multiplier itself SHALL stay external.

Verification
REQ-027 req0, 3 * -4 -> gnt0 pulse; after mul_done, rsp_valid0 with rsp_prod=-12 (9'h1F4) and rsp_err=0; rsp_valid1 stays 0.
REQ-028 req1, -5 * 7 -> rsp_valid1 with rsp_prod=-35 (9'h1DD) and rsp_err=0.
REQ-029 req0 (-8 * -3) and req1 (6 * 2) raised in the same cycle after reset -> gnt0 first, rsp0=24; then gnt1, rsp1=12. Repeat with both held high -> grants alternate 0,1,0,1.
REQ-030 mul_done tied low -> rsp_valid with rsp_err=1 and rsp_prod=0 exactly TIMEOUT_CYC cycles after entering WAIT; then a normal job 7 * -7 -> -49.
REQ-031 rst_n low during WAIT -> all outputs 0 immediately, no rsp_valid; after release, a pending req0 is granted within 1 cycle.
REQ-032 mul_done pulsed high while in IDLE -> no rsp_valid and no state change.

Source files
------------

// File: rtl/mult4x4_arbiter_pkg.sv
// Shared types and constants for the two-requester arbiter in front of
// the external sequential 4x4 signed multiplier.
package mult4x4_arbiter_pkg;

    localparam int OP_W            = 4;
    localparam int PROD_W          = 9;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Requester index to one-hot {req1, req0} strobe.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        logic [1:0] oh;
        oh = 2'b00;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mult4x4_arbiter_if.sv
// Handshake between the arbiter and one sequential_signed_mult4x4 instance.
interface mult4x4_arbiter_if;
    import mult4x4_arbiter_pkg::*;

    logic                     mul_st;
    logic signed [OP_W-1:0]   mul_mplier;
    logic signed [OP_W-1:0]   mul_mcand;
    logic signed [PROD_W-1:0] mul_prod;
    logic                     mul_done;

    modport master (
        output mul_st,
        output mul_mplier,
        output mul_mcand,
        input  mul_prod,
        input  mul_done
    );

    modport slave (
        input  mul_st,
        input  mul_mplier,
        input  mul_mcand,
        output mul_prod,
        output mul_done
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the pointer remembers the last requester granted
// and only moves when the caller actually takes a grant.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic win,
    output logic any
);

    logic last_r;

    // Winner selection: contention favours the requester not granted last.
    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            win = ~last_r;
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
    end

    // Pointer register; reset value 1 gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (take && any) begin
            last_r <= win;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/mult4x4_arbiter.sv
// Arbitrates two requesters onto one external sequential multiplier, one job
// at a time, with a WAIT timeout that returns an error response.
module mult4x4_arbiter
    import mult4x4_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic signed [OP_W-1:0]   mplier0,
    input  logic signed [OP_W-1:0]   mcand0,
    input  logic signed [OP_W-1:0]   mplier1,
    input  logic signed [OP_W-1:0]   mcand1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rsp_valid0,
    output logic                     rsp_valid1,
    output logic signed [PROD_W-1:0] rsp_prod,
    output logic                     rsp_err,
    mult4x4_arbiter_if.master        mul
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    // RESP adds one cycle before rsp_valid, so the abort is decided one WAIT
    // edge early to land rsp_valid exactly TIMEOUT_CYC cycles after WAIT entry.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 2 : 0);

    arb_state_e       state_r;
    logic             win_r;
    logic [CNT_W-1:0] cnt_r;
    logic             arb_win_s;
    logic             arb_any_s;
    logic             arb_take_s;

    assign arb_take_s = (state_r == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .take  (arb_take_s),
        .win   (arb_win_s),
        .any   (arb_any_s)
    );

    // Job sequencer: grant/capture, start pulse, wait with timeout, response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            win_r          <= 1'b0;
            cnt_r          <= '0;
            gnt0           <= 1'b0;
            gnt1           <= 1'b0;
            rsp_valid0     <= 1'b0;
            rsp_valid1     <= 1'b0;
            rsp_prod       <= '0;
            rsp_err        <= 1'b0;
            mul.mul_st     <= 1'b0;
            mul.mul_mplier <= '0;
            mul.mul_mcand  <= '0;
        end else begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            mul.mul_st <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_any_s) begin
                        {gnt1, gnt0}   <= idx_to_onehot(arb_win_s);
                        win_r          <= arb_win_s;
                        mul.mul_mplier <= arb_win_s ? mplier1 : mplier0;
                        mul.mul_mcand  <= arb_win_s ? mcand1 : mcand0;
                        mul.mul_st     <= 1'b1;
                        state_r        <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    cnt_r   <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul.mul_done) begin
                        rsp_prod <= mul.mul_prod;
                        rsp_err  <= 1'b0;
                        state_r  <= ST_RESP;
                    end else if (cnt_r == TO_LAST) begin
                        rsp_prod <= '0;
                        rsp_err  <= 1'b1;
                        state_r  <= ST_RESP;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    {rsp_valid1, rsp_valid0} <= idx_to_onehot(win_r);
                    state_r                  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
